// File: rtl/fetch_decode.sv
// Instruction fetch and field-split stage: fetches over req/ack, maintains the PC,
// and presents opcode/imm5/ext_en/pc_out to execute over valid/ready.
module fetch_decode #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] opcode,
  output logic [4:0] imm5,
  output logic       ext_en,
  output logic [7:0] pc_out,
  input  logic       branch_en,
  input  logic [7:0] branch_target,
  output logic       halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_HLT  = 3'b111;

  state_t     state;
  logic [7:0] pc;
  logic       flush;
  logic       accept;

  function automatic logic uses_imm(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_LDI) || (op == OP_BEQ);
  endfunction

  assign accept = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= RESET_PC;
      out_valid <= 1'b0;
      opcode    <= '0;
      imm5      <= '0;
      ext_en    <= 1'b0;
      pc_out    <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_req  <= 1'b1;
          mem_addr <= pc;
          state    <= FETCH;
        end

        FETCH: begin
          if (mem_ack) begin
            if (flush || branch_en) begin
              // Redirected fetch: drop the data and keep requesting, now at the target.
              flush    <= 1'b0;
              pc       <= branch_en ? branch_target : pc;
              mem_addr <= branch_en ? branch_target : pc;
            end else begin
              opcode    <= mem_rdata[7:5];
              imm5      <= mem_rdata[4:0];
              ext_en    <= uses_imm(mem_rdata[7:5]);
              pc_out    <= pc;
              out_valid <= 1'b1;
              mem_req   <= 1'b0;
              pc        <= pc + 8'd1;
              state     <= HOLD;
            end
          end else if (branch_en) begin
            // Request address stays put until the outstanding ack arrives.
            flush <= 1'b1;
            pc    <= branch_target;
          end
        end

        HOLD: begin
          if (branch_en) begin
            out_valid <= 1'b0;
            pc        <= branch_target;
            mem_req   <= 1'b1;
            mem_addr  <= branch_target;
            state     <= FETCH;
          end else if (accept) begin
            out_valid <= 1'b0;
            if (opcode == OP_HLT) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= pc;
              state    <= FETCH;
            end
          end
        end

        HALT: begin
          if (branch_en) begin
            halted   <= 1'b0;
            pc       <= branch_target;
            mem_req  <= 1'b1;
            mem_addr <= branch_target;
            state    <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and field-split stage of the 8-bit computer. Fetches 8-bit instruction words from instruction memory over a req/ack handshake and maintains the program counter. Splits each word into opcode and 5-bit immediate, and presents them to the execute side over a valid/ready handshake. The `imm5`/`ext_en` pair feeds the immediate sign-extender directly downstream (5-bit in, 8-bit out).

## Interface
Parameters:
- `RESET_PC`, 8'h00, PC value loaded on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  instruction read request.
- `mem_addr`  out  8  read address; equals current PC while `mem_req`=1.
- `mem_ack`  in  1  read data valid this cycle; sampled only while `mem_req`=1.
- `mem_rdata`  in  8  instruction word; valid when `mem_ack`=1.
- `out_valid`  out  1  decoded instruction available.
- `out_ready`  in  1  consumer accepts the instruction when `out_valid`=1.
- `opcode`  out  3  `instr[7:5]`.
- `imm5`  out  5  `instr[4:0]`; to sign-extender data input.
- `ext_en`  out  1  1 for immediate-using opcodes (3'b001 ADDI, 3'b100 LDI, 3'b101 BEQ), else 0; to sign-extender control.
- `pc_out`  out  8  address the presented instruction was fetched from.
- `branch_en`  in  1  redirect request from execute.
- `branch_target`  in  8  redirect address; valid when `branch_en`=1.
- `halted`  out  1  1 while in HALT.

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- IDLE: entered only on reset. Next cycle goes to FETCH with `mem_req`<=1 and `mem_addr`<=PC.
- FETCH:
  - `mem_req`=1; `mem_addr` held stable until ack.
  - On `mem_ack`: latch `opcode`/`imm5`/`ext_en`/`pc_out` from `mem_rdata`/PC, `out_valid`<=1, `mem_req`<=0, PC<=PC+1, go to HOLD.
- HOLD:
  - Output registers frozen while `out_valid`=1 and `out_ready`=0.
  - On accept (`out_valid`&`out_ready`):
    - If `opcode`=3'b111 (HLT), `out_valid`<=0 and go to HALT.
    - Otherwise go to FETCH, `mem_req`<=1 at new PC, `out_valid`<=0.
- HALT: no requests, `halted`=1. Leave only on `reset` or `branch_en`; `branch_en` goes to FETCH at `branch_target`.
- PC arithmetic: 8-bit, wraps 8'hFF -> 8'h00 without flag.
- Branch rules (`branch_en` sampled every cycle):
  - In FETCH before ack: set internal flush flag, PC<=`branch_target`. `mem_req`/`mem_addr` stay unchanged until the outstanding ack arrives. That ack's data is discarded (no `out_valid`, PC not incremented), then re-request at `branch_target` on the next cycle.
  - In FETCH in the same cycle as `mem_ack`: data discarded, as above.
  - In HOLD without accept: presented instruction dropped (`out_valid`<=0), FETCH at target.
  - In HOLD with simultaneous accept: transfer counts; PC<=target; FETCH at target (HLT not entered).
- `ext_en` is a registered function of the latched opcode and changes only when new data is latched.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `out_valid`=0, `opcode`=0, `imm5`=0, `ext_en`=0, `pc_out`=0, `halted`=0; PC=`RESET_PC`; flush flag clear; state IDLE.
- Reset mid-handshake aborts everything; a late `mem_ack` while `mem_req`=0 is ignored.
- First `mem_req` is high 1 cycle after the first edge with `reset`=0.
- Latency is 1 cycle from the `mem_ack` edge to `out_valid`=1.
- Zero-wait memory (ack in the first request cycle) gives a peak throughput of 1 instruction per 2 cycles.
- `mem_req` never drops without ack, except on reset.

## Test plan
- Reset, then memory with ack 1 cycle after req, holding 8'h3A at address 0 -> `mem_addr`=0; `out_valid`=1 with `opcode`=3'b001, `imm5`=5'b11010, `ext_en`=1, `pc_out`=0; next fetch address 1.
- Same word with `out_ready` held low 5 cycles -> outputs stable, no `mem_req`, PC stays 1 until accept.
- Branch to 8'h40 asserted in the cycle after `mem_req` rises, with ack delayed 3 cycles -> `mem_addr` stable for the full wait; that data is not presented; next `mem_req` has `mem_addr`=8'h40.
- `RESET_PC`=8'hFF, sequential fetch -> second fetch address 8'h00.
- Word 8'hE0 (HLT) accepted -> `halted`=1 and no `mem_req` for 20 cycles; `branch_en` to 8'h10 -> FETCH at 8'h10, `halted`=0.
- Reset asserted while `out_valid`=1 and a request is pending -> all outputs at reset values next cycle; fetch restarts at `RESET_PC`.
